fetch_stage: RTL



---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 57 +++++
 rtl/fetch_stage.sv | 109 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP  = 32'd4;
  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {instruction, pc} entries.
// Flush wins over push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           pop,
  input  logic                           flush,
  input  fetch_entry_t                   wr_entry,
  output fetch_entry_t                   head,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !flush && (!full || pop);
  assign do_pop  = pop && !flush && !empty;
  assign head    = mem[rd_ptr];

  // NOTE: the storage array is deliberately not reset; only pointers and count need a known state.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_entry;
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so every reader sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues credit-limited memory requests,
// buffers responses and drops stale in-flight responses after a redirect.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] dec_inst,
  output logic [XLEN-1:0] dec_pc
);

  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  fetch_entry_t    fifo_head;
  fetch_entry_t    push_entry;
  logic            pop;
  logic            push;
  logic            accept;
  logic [CW:0]     inflight;
  logic [XLEN-1:0] target_pc;

  assign target_pc = redirect_pc & ~32'h3;

  // Credit counts both in-flight requests and buffered entries, so a
  // response always has a free FIFO slot waiting for it.
  // NOTE: every signal written in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    pop            = 1'b0;
    push           = 1'b0;
    inflight       = '0;
    imem_req_valid = 1'b0;
    dec_valid      = 1'b0;
    dec_valid      = !fifo_empty && !redirect_valid;
    pop            = dec_valid && dec_ready;
    inflight       = {1'b0, outstanding} + {1'b0, fifo_count} - {{CW{1'b0}}, pop};
    imem_req_valid = !rst && !redirect_valid && (inflight < DEPTH_C);
    push           = imem_rsp_valid && !redirect_valid && (drop_cnt == '0);
  end

  assign accept         = imem_req_valid && imem_req_ready;
  assign imem_req_addr  = pc;
  assign push_entry     = '{inst: imem_rsp_data, pc: rsp_pc};
  assign dec_inst       = fifo_head.inst;
  assign dec_pc         = fifo_head.pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(imem_rsp_valid);
      if (redirect_valid) begin
        pc       <= target_pc;
        rsp_pc   <= target_pc;
        drop_cnt <= outstanding - CW'(imem_rsp_valid);
      end else begin
        if (accept) pc <= pc + PC_STEP;
        if (imem_rsp_valid) begin
          if (drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
          else                rsp_pc   <= rsp_pc + PC_STEP;
        end
      end
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .flush    (redirect_valid),
    .wr_entry (push_entry),
    .head     (fifo_head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  a_credit: assert property (@(posedge clk) disable iff (rst)
    ({1'b0, outstanding} + {1'b0, fifo_count}) <= DEPTH_C);
  a_drop: assert property (@(posedge clk) disable iff (rst) drop_cnt <= outstanding);
  a_no_spurious_rsp: assert property (@(posedge clk) disable iff (rst)
    !(imem_rsp_valid && outstanding == '0));
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && fifo_full && !pop));

endmodule
